// File: rtl/cpu_dbg_pkg.sv
// Shared encodings for the CPU debug run-control block: host opcodes,
// controller states and the default step-counter width.
package cpu_dbg_pkg;

   localparam int unsigned STEP_W_DEF = 16;
   localparam int unsigned AW_DEF     = 32;
   localparam int unsigned DW_DEF     = 32;

   typedef enum logic [1:0] {
      OP_HALT   = 2'b00,
      OP_STEP   = 2'b01,
      OP_RUN    = 2'b10,
      OP_MEMACC = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_HALTED   = 2'b00,
      ST_STEPPING = 2'b01,
      ST_RUNNING  = 2'b10,
      ST_MEM      = 2'b11
   } state_e;

endpackage

// File: rtl/dbg_dmem_mux.sv
// DMEM port selection: the debug host owns the port during a memory access,
// otherwise the CPU does, with its writes gated by the clock enable.
module dbg_dmem_mux
   import cpu_dbg_pkg::*;
#(
   parameter int unsigned AW = AW_DEF,
   parameter int unsigned DW = DW_DEF
) (
   input  logic          sel_dbg,
   input  logic          cpu_ce,
   input  logic [AW-1:0] cpu_daddr,
   input  logic [DW-1:0] cpu_dwdata,
   input  logic [3:0]    cpu_we,
   input  logic [AW-1:0] dbg_addr,
   input  logic [DW-1:0] dbg_wdata,
   input  logic [3:0]    dbg_we,
   output logic [AW-1:0] dmem_addr_c,
   output logic [DW-1:0] dmem_wdata_c,
   output logic [3:0]    dmem_we_c
);

   always_comb begin
      dmem_addr_c  = cpu_daddr;
      dmem_wdata_c = cpu_dwdata;
      dmem_we_c    = cpu_we & {4{cpu_ce}};
      if (sel_dbg) begin
         dmem_addr_c  = dbg_addr;
         dmem_wdata_c = dbg_wdata;
         dmem_we_c    = dbg_we;
      end
   end

endmodule

// File: rtl/cpu_debug_ctrl.sv
// Run-control (halt / step N / run / PC breakpoint) for the debug-board CPU,
// plus host single-word DMEM access while the CPU is halted.
module cpu_debug_ctrl
   import cpu_dbg_pkg::*;
#(
   parameter int unsigned STEP_W = STEP_W_DEF,
   parameter int unsigned AW     = AW_DEF,
   parameter int unsigned DW     = DW_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [STEP_W-1:0] cmd_count,
   input  logic [AW-1:0]     cmd_addr,
   input  logic [DW-1:0]     cmd_wdata,
   input  logic [3:0]        cmd_we,
   input  logic              bp_en,
   input  logic [AW-1:0]     bp_addr,
   input  logic [AW-1:0]     pc,
   output logic              cpu_ce,
   input  logic [AW-1:0]     cpu_daddr,
   input  logic [DW-1:0]     cpu_dwdata,
   input  logic [3:0]        cpu_we,
   output logic [AW-1:0]     dmem_addr,
   output logic [DW-1:0]     dmem_wdata,
   output logic [3:0]        dmem_we,
   input  logic [DW-1:0]     dmem_rdata,
   output logic [DW-1:0]     dbg_rdata,
   output logic              dbg_done,
   output logic              halted,
   output logic              bp_hit,
   output logic [STEP_W-1:0] steps_left
);

   state_e            state_q, state_d;
   logic              first_q, first_d;
   logic [STEP_W-1:0] steps_q, steps_d;
   logic              bp_hit_q, bp_hit_d;
   logic              dbg_done_q, dbg_done_d;
   logic [DW-1:0]     dbg_rdata_q, dbg_rdata_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic [DW-1:0]     wdata_q, wdata_d;
   logic [3:0]        we_q, we_d;

   logic bp_match;
   logic active;
   logic cmd_acc;

   // first_q masks the breakpoint for one cycle so resuming at bp_addr executes it
   assign active    = (state_q == ST_STEPPING) || (state_q == ST_RUNNING);
   assign bp_match  = bp_en && (pc == bp_addr) && !first_q;
   assign cpu_ce    = active && !bp_match;
   assign cmd_ready = (state_q == ST_HALTED) || (state_q == ST_RUNNING);
   assign cmd_acc   = cmd_valid && cmd_ready;

   assign halted     = (state_q == ST_HALTED);
   assign bp_hit     = bp_hit_q;
   assign dbg_done   = dbg_done_q;
   assign dbg_rdata  = dbg_rdata_q;
   assign steps_left = steps_q;

   always_comb begin
      state_d     = state_q;
      first_d     = 1'b0;
      steps_d     = steps_q;
      bp_hit_d    = bp_hit_q;
      dbg_done_d  = 1'b0;
      dbg_rdata_d = dbg_rdata_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      we_d        = we_q;
      case (state_q)
         ST_HALTED: begin
            if (cmd_acc) begin
               case (cmd_op)
                  OP_STEP: begin
                     if (cmd_count != '0) begin
                        state_d  = ST_STEPPING;
                        steps_d  = cmd_count;
                        bp_hit_d = 1'b0;
                        first_d  = 1'b1;
                     end
                  end
                  OP_RUN: begin
                     state_d  = ST_RUNNING;
                     bp_hit_d = 1'b0;
                     first_d  = 1'b1;
                  end
                  OP_MEMACC: begin
                     state_d = ST_MEM;
                     addr_d  = cmd_addr;
                     wdata_d = cmd_wdata;
                     we_d    = cmd_we;
                  end
                  default: ;
               endcase
            end
         end
         ST_STEPPING: begin
            if (bp_match) begin
               state_d  = ST_HALTED;
               bp_hit_d = 1'b1;
            end else begin
               if (steps_q != '0) steps_d = steps_q - STEP_W'(1);
               if (steps_q == STEP_W'(1)) state_d = ST_HALTED;
            end
         end
         ST_RUNNING: begin
            // a breakpoint takes priority over a HALT in the same cycle
            if (bp_match) begin
               state_d  = ST_HALTED;
               bp_hit_d = 1'b1;
            end else if (cmd_acc && (cmd_op == OP_HALT)) begin
               state_d = ST_HALTED;
            end
         end
         ST_MEM: begin
            dbg_rdata_d = dmem_rdata;
            dbg_done_d  = 1'b1;
            state_d     = ST_HALTED;
         end
         default: state_d = ST_HALTED;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_HALTED;
         first_q     <= 1'b0;
         steps_q     <= '0;
         bp_hit_q    <= 1'b0;
         dbg_done_q  <= 1'b0;
         dbg_rdata_q <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         we_q        <= '0;
      end else begin
         state_q     <= state_d;
         first_q     <= first_d;
         steps_q     <= steps_d;
         bp_hit_q    <= bp_hit_d;
         dbg_done_q  <= dbg_done_d;
         dbg_rdata_q <= dbg_rdata_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         we_q        <= we_d;
      end
   end

   dbg_dmem_mux #(.AW(AW), .DW(DW)) u_mux (
      .sel_dbg      (state_q == ST_MEM),
      .cpu_ce       (cpu_ce),
      .cpu_daddr    (cpu_daddr),
      .cpu_dwdata   (cpu_dwdata),
      .cpu_we       (cpu_we),
      .dbg_addr     (addr_q),
      .dbg_wdata    (wdata_q),
      .dbg_we       (we_q),
      .dmem_addr_c  (dmem_addr),
      .dmem_wdata_c (dmem_wdata),
      .dmem_we_c    (dmem_we)
   );

endmodule
